// File: rtl/spike_actuator_array.sv
// Spiking-input actuator array: each channel integrates excitatory/inhibitory
// spikes into a clamped motor command that decays on a shared prescaled tick.
module spike_actuator_array #(
  parameter int NUM_CH    = 4,
  parameter int CMD_W     = 8,
  parameter int INC       = 10,
  parameter int INH       = 10,
  parameter int DEC_STEP  = 1,
  parameter int DECAY_DIV = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       spike_exc,
  input  logic [NUM_CH-1:0]       spike_inh,
  output logic [NUM_CH*CMD_W-1:0] motor_command,
  output logic [NUM_CH-1:0]       saturated,
  output logic                    cmd_valid
);

  localparam int PW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DECAY_DIV - 1);
  localparam logic [CMD_W-1:0] CMD_MAX  = {CMD_W{1'b1}};
  localparam logic [CMD_W:0]   INC_X    = (CMD_W+1)'(INC);
  localparam logic [CMD_W:0]   INH_X    = (CMD_W+1)'(INH);
  localparam logic [CMD_W:0]   DEC_X    = (CMD_W+1)'(DEC_STEP);

  // Sums carry one extra bit so the clamp sees overflow instead of a wrap.
  function automatic logic [CMD_W-1:0] sat_add(input logic [CMD_W-1:0] a,
                                               input logic [CMD_W:0]   b);
    logic [CMD_W:0] s;
    s = {1'b0, a} + b;
    return s[CMD_W] ? CMD_MAX : s[CMD_W-1:0];
  endfunction

  // Borrow out of the extended difference means the result went below zero.
  function automatic logic [CMD_W-1:0] sat_sub(input logic [CMD_W-1:0] a,
                                               input logic [CMD_W:0]   b);
    logic [CMD_W:0] d;
    d = {1'b0, a} - b;
    return d[CMD_W] ? '0 : d[CMD_W-1:0];
  endfunction

  logic [PW-1:0]    presc_p0;
  logic             tick;
  logic [CMD_W-1:0] cmd_p1 [NUM_CH];
  logic [CMD_W-1:0] cmd_nxt [NUM_CH];
  logic [NUM_CH-1:0] sat_p1;
  logic [NUM_CH-1:0] sat_nxt;
  logic             vld_p1;
  logic             changed;

  assign tick = enable && (presc_p0 == PRE_LAST);

  // Stage 0 -> 1: per-channel next command; coincident spikes cancel.
  always_comb begin
    changed = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      cmd_nxt[c] = cmd_p1[c];
      if (enable) begin
        if (spike_exc[c] && !spike_inh[c])
          cmd_nxt[c] = sat_add(cmd_p1[c], INC_X);
        else if (spike_inh[c] && !spike_exc[c])
          cmd_nxt[c] = sat_sub(cmd_p1[c], INH_X);
        else if (tick)
          cmd_nxt[c] = sat_sub(cmd_p1[c], DEC_X);
      end
      sat_nxt[c] = (cmd_nxt[c] == CMD_MAX);
      if (cmd_nxt[c] != cmd_p1[c])
        changed = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_p0 <= '0;
      sat_p1   <= '0;
      vld_p1   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        cmd_p1[c] <= '0;
    end else begin
      if (enable)
        presc_p0 <= (presc_p0 == PRE_LAST) ? '0 : presc_p0 + 1'b1;
      sat_p1 <= sat_nxt;
      vld_p1 <= changed;
      for (int c = 0; c < NUM_CH; c++)
        cmd_p1[c] <= cmd_nxt[c];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign motor_command[g*CMD_W +: CMD_W] = cmd_p1[g];
  end

  assign saturated = sat_p1;
  assign cmd_valid = vld_p1;

endmodule

// File: tb/tb_spike_actuator_array.sv
// Directed bench for spike_actuator_array at default parameters.
module tb_spike_actuator_array;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [3:0]  spike_exc, spike_inh;
  logic [31:0] motor_command;
  logic [3:0]  saturated;
  logic        cmd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  spike_actuator_array dut (
    .clk(clk), .rst(rst), .enable(enable),
    .spike_exc(spike_exc), .spike_inh(spike_inh),
    .motor_command(motor_command), .saturated(saturated), .cmd_valid(cmd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        en;
    logic [3:0]  e;
    logic [3:0]  i;
    logic [31:0] cmd;
    logic [3:0]  sat;
    logic        vld;
  } vec_t;

  vec_t tbl [11];

  task automatic step(input logic r, input logic en, input logic [3:0] e, input logic [3:0] i);
    rst = r; enable = en; spike_exc = e; spike_inh = i;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] ecmd,
                       input logic [3:0] esat, input logic evld);
    n_tests += 3;
    if (motor_command !== ecmd) begin
      n_fail++;
      $display("FAIL %s cmd: got %h want %h", name, motor_command, ecmd);
    end
    if (saturated !== esat) begin
      n_fail++;
      $display("FAIL %s sat: got %b want %b", name, saturated, esat);
    end
    if (cmd_valid !== evld) begin
      n_fail++;
      $display("FAIL %s vld: got %b want %b", name, cmd_valid, evld);
    end
  endtask

  initial begin
    logic [7:0] exp8;
    logic       ev;
    rst = 1'b1; enable = 1'b0; spike_exc = '0; spike_inh = '0;

    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'h1, 4'h0, 32'h0000_000A, 4'h0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 4'h1, 4'h0, 32'h0000_0014, 4'h0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 4'h1, 4'h0, 32'h0000_001E, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 4'h8, 4'h0, 32'h0A00_001E, 4'h0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'h8, 4'h8, 32'h0A00_001E, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'h0, 4'h8, 32'h0000_001E, 4'h0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 4'h8, 32'h0000_001E, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 4'h0, 32'h0000_001E, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'h2, 4'h1, 32'h0000_0A14, 4'h0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 4'hF, 4'h0, 32'h0000_0000, 4'h0, 1'b0};

    for (int k = 0; k < 11; k++) begin
      step(tbl[k].r, tbl[k].en, tbl[k].e, tbl[k].i);
      check($sformatf("vec%0d", k), tbl[k].cmd, tbl[k].sat, tbl[k].vld);
    end

    // Saturation on ch1: 10 per spike up to 250, then clamp at 255.
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int k = 1; k <= 29; k++) begin
      step(1'b0, 1'b1, 4'h2, 4'h0);
      exp8 = (k >= 26) ? 8'd255 : 8'(10 * k);
      check($sformatf("sat_k%0d", k), {16'h0, exp8, 8'h0},
            (k >= 26) ? 4'h2 : 4'h0, (k <= 26));
    end

    // Decay on ch2 from 10: one step every 16 enabled cycles down to 0.
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int n = 1; n <= 200; n++) begin
      step(1'b0, 1'b1, (n == 1) ? 4'h4 : 4'h0, 4'h0);
      exp8 = (n == 1) ? 8'd10 : 8'(10 - ((n / 16 > 10) ? 10 : n / 16));
      ev   = (n == 1) || ((n % 16 == 0) && (n / 16 <= 10));
      if (n <= 20 || n >= 140)
        check($sformatf("decay_n%0d", n), {8'h0, exp8, 16'h0}, 4'h0, ev);
    end

    // Freeze with enable low at prescaler 9, then resume: tick after 7 more.
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 4'h1, 4'h0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 4'h0, 4'h0);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 4'hF, (k % 2 == 0) ? 4'h0 : 4'hF);
      if (k % 8 == 7) check($sformatf("frz%0d", k), 32'h0000_000A, 4'h0, 1'b0);
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, 4'h0, 4'h0);
      if (k >= 6)
        check($sformatf("resume%0d", k), (k == 7) ? 32'h9 : 32'hA, 4'h0, k == 7);
    end

    // Reset mid-operation with ch0=30, prescaler=9; first tick 16 cycles later.
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'h1, 4'h0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 4'h0, 4'h0);
    check("pre_rst", 32'h0000_001E, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'h0);
    check("rst_mid", 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h8, 4'h0);
    check("post_rst1", 32'h0A00_0000, 4'h0, 1'b1);
    for (int n = 2; n <= 16; n++) begin
      step(1'b0, 1'b1, 4'h0, 4'h0);
      if (n >= 15)
        check($sformatf("post_rst%0d", n), (n == 16) ? 32'h0900_0000 : 32'h0A00_0000,
              4'h0, n == 16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
